// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, keeps one fetch in flight,
// parks a response that lands during a stall, and drops fetches made stale by a redirect.
// state | meaning
// IDLE  | no request outstanding
// WAIT  | one request outstanding, response wanted
// DROP  | one request outstanding, response to be discarded
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        if_id_flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] id_inst_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic [31:0] redirect_pc_al;
  logic        capture, to_buf, consume, drain, buf_free, accept;

  assign redirect_pc_al = redirect_pc_i & ~32'h0000_0003;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid_i)         state_d = accept ? S_WAIT : S_IDLE;
        else if (redirect_valid_i) state_d = S_DROP;
      end
      S_DROP: if (imem_rvalid_i) state_d = accept ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A buffer being drained or cleared this cycle counts as free, so fetch continues without a gap.
  always_comb begin
    capture     = (state_q == S_WAIT) && imem_rvalid_i && !redirect_valid_i;
    to_buf      = capture && stall_i && !if_id_flush_i;
    consume     = capture && !to_buf;
    drain       = buf_valid_q && !stall_i && !if_id_flush_i;
    buf_free    = !buf_valid_q || drain || redirect_valid_i;
    imem_req_o  = !rst && buf_free && ((state_q == S_IDLE) || (imem_rvalid_i && !to_buf));
    imem_addr_o = redirect_valid_i ? redirect_pc_al : pc_q;
    accept      = imem_req_o && imem_ready_i;
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;

    if (accept) begin
      pc_d     = imem_addr_o + 32'd4;
      req_pc_d = imem_addr_o;
    end else if (redirect_valid_i) begin
      pc_d = redirect_pc_al;
    end

    if (redirect_valid_i || drain) begin
      buf_valid_d = 1'b0;
    end else if (to_buf) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = req_pc_q;
      buf_inst_d  = imem_rdata_i;
    end

    if (if_id_flush_i) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else if (!stall_i) begin
      if (buf_valid_q) begin
        id_valid_d = 1'b1;
        id_pc_d    = buf_pc_q;
        id_inst_d  = buf_inst_q;
      end else if (consume) begin
        id_valid_d = 1'b1;
        id_pc_d    = req_pc_q;
        id_inst_d  = imem_rdata_i;
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = NOP_INST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_inst_q  <= NOP_INST;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= NOP_INST;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
    end
  end

  assign id_valid_o = id_valid_q;
  assign id_pc_o    = id_pc_q;
  assign id_pc4_o   = id_pc_q + 32'd4;
  assign id_inst_o  = id_inst_q;

endmodule
